// File: rtl/ahb_apb_pkg.sv
// Shared encodings, FSM state type and sizing helper for the AHB-Lite to APB bridge.
// Pure declarations; no timing or backpressure of its own.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2,
    ST_DONE
  } state_t;

  // Bit width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_apb_slv_decode.sv
// Slave index decode: one-hot select, decode-error flag, prdata/pready/pslverr mux.
// Purely combinational, zero latency; carries no backpressure of its own.
module ahb_apb_slv_decode
  import ahb_apb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int NUM_SLV = 4,
  parameter int IW      = clog2_min1(NUM_SLV)
) (
  input  logic [IW-1:0]         req_idx,
  input  logic [IW-1:0]         idx,
  input  logic [NUM_SLV*DW-1:0] prdata,
  input  logic [NUM_SLV-1:0]    pready,
  input  logic [NUM_SLV-1:0]    pslverr,
  output logic [NUM_SLV-1:0]    sel,
  output logic                  dec_err,
  output logic [DW-1:0]         rdata,
  output logic                  rdy,
  output logic                  err
);

  // The address index field can encode more slaves than exist when NUM_SLV is not a power of two.
  assign dec_err = (int'(req_idx) >= NUM_SLV);

  always_comb begin
    sel   = '0;
    rdata = '0;
    rdy   = 1'b0;
    err   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (int'(idx) == i) begin
        sel[i] = 1'b1;
        rdata  = prdata[i*DW +: DW];
        rdy    = pready[i];
        err    = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite slave to NUM_SLV-port APB master; 2 wait states minimum, holds hr_readyout low while pready is low.
// AHB_APB_BRIDGE_APB4_EN adds hsize/pstrb/pprot; pslverr, decode miss and wait timeout return a two-cycle ERROR.
module ahb_apb_bridge_mc
  import ahb_apb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [AW-1:0]         haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [DW-1:0]         hwdata,
  input  logic                  hreadyin,
`ifdef AHB_APB_BRIDGE_APB4_EN
  input  logic [2:0]            hsize,
  output logic [DW/8-1:0]       pstrb,
  output logic [2:0]            pprot,
`endif
  output logic [DW-1:0]         hrdata,
  output logic                  hr_readyout,
  output logic [1:0]            hresp,
  output logic [AW-1:0]         paddr,
  output logic [DW-1:0]         pwdata,
  output logic                  pwrite,
  output logic [NUM_SLV-1:0]    psel,
  output logic                  penable,
  input  logic [NUM_SLV*DW-1:0] prdata,
  input  logic [NUM_SLV-1:0]    pready,
  input  logic [NUM_SLV-1:0]    pslverr
);

  localparam int IW = clog2_min1(NUM_SLV);
  localparam int CW = clog2_min1(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [AW-1:0]        addr_q;
  logic                 write_q;
  logic [IW-1:0]        idx_q;
  logic [DW-1:0]        pwdata_q;
  logic [DW-1:0]        hrdata_q;
  logic [CW-1:0]        cnt_q;

  logic [IW-1:0]        req_idx;
  logic [NUM_SLV-1:0]   sel_vec;
  logic                 dec_err;
  logic [DW-1:0]        slv_rdata;
  logic                 slv_rdy;
  logic                 slv_err;
  logic                 accept;
  logic                 timeout_hit;

  assign req_idx = haddr[SEL_LSB +: IW];

  // Address phases are taken only where hr_readyout is high and the bus is not in an ERROR tail.
  assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                  hsel && hreadyin && htrans_active(htrans);

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  ahb_apb_slv_decode #(
    .DW      (DW),
    .NUM_SLV (NUM_SLV),
    .IW      (IW)
  ) u_decode (
    .req_idx (req_idx),
    .idx     (idx_q),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .sel     (sel_vec),
    .dec_err (dec_err),
    .rdata   (slv_rdata),
    .rdy     (slv_rdy),
    .err     (slv_err)
  );

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = dec_err ? ST_ERR1 : ST_SETUP;
        else        state_d = ST_IDLE;
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (slv_rdy)          state_d = slv_err ? ST_ERR1 : ST_DONE;
        else if (timeout_hit) state_d = ST_ERR1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hr_readyout = 1'b1;
    hresp       = HRESP_OKAY;
    psel        = '0;
    penable     = 1'b0;
    case (state_q)
      ST_SETUP: begin
        hr_readyout = 1'b0;
        psel        = sel_vec;
      end
      ST_ACCESS: begin
        hr_readyout = 1'b0;
        psel        = sel_vec;
        penable     = 1'b1;
      end
      ST_ERR1: begin
        hr_readyout = 1'b0;
        hresp       = HRESP_ERROR;
      end
      ST_ERR2:  hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        idx_q   <= req_idx;
      end
      if (state_q == ST_SETUP) begin
        cnt_q <= '0;
        if (write_q) pwdata_q <= hwdata;
      end
      if (state_q == ST_ACCESS) begin
        if (!slv_rdy)                       cnt_q    <= cnt_q + 1'b1;
        else if (!slv_err && !write_q)      hrdata_q <= slv_rdata;
      end
    end
  end

  // hwdata is only valid during SETUP, so it is passed straight through there and held afterwards.
  assign pwdata = ((state_q == ST_SETUP) && write_q) ? hwdata : pwdata_q;
  assign paddr  = addr_q;
  assign pwrite = write_q;
  assign hrdata = hrdata_q;

`ifdef AHB_APB_BRIDGE_APB4_EN
  localparam int SW = DW / 8;
  localparam int LW = clog2_min1(SW);

  logic [SW-1:0] pstrb_q;

  function automatic logic [SW-1:0] strb_of(input logic [2:0] size, input logic [LW-1:0] lo);
    int unsigned nb;
    int unsigned off;
    logic [SW-1:0] m;
    nb = 32'd1 << size;
    if (nb >= SW) begin
      m = '1;
    end else begin
      off = 32'(lo) & ~(nb - 32'd1);
      m   = SW'(((32'd1 << nb) - 32'd1) << off);
    end
    return m;
  endfunction

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)      pstrb_q <= '0;
    else if (accept) pstrb_q <= hwrite ? strb_of(hsize, haddr[LW-1:0]) : '0;
  end

  assign pstrb = pstrb_q;
  assign pprot = 3'b000;
`endif

endmodule
